// File: rtl/tx_sample_buffer.sv
// -----------------------------------------------------------------------------
// tx_sample_buffer
//
// Buffers 12-bit ADC samples in a circular FIFO and presents one word at a
// time to a nibble transmitter. A word is offered on TxData while idle, is
// frozen for the three-nibble handshake (NIB0..NIB2), and is popped when the
// third Ack falling edge completes the transfer.
//
// Handshake: Req starts a transfer from IDLE. Each nibble is closed by a
// falling edge of Ack, seen as the registered Ack being 1 while the live Ack
// is 0. The transmitter may sample TxData at any point between Req and the
// third Ack fall; TxData does not change during that window.
//
// Ports
//   ExtClk     in   system clock, rising edge
//   ExtResetn  in   asynchronous active-low reset
//   AdcData    in   [11:0] sample from the ADC capture stage
//   AdcValid   in   one-cycle strobe qualifying AdcData
//   Clear      in   synchronous flush of FIFO and sticky flags
//   Req        in   transfer request
//   Ack        in   nibble acknowledge from the transmitter
//   TxData     out  [11:0] word presented to the transmitter
//   DataAvail  out  FIFO holds at least one word (registered)
//   Count      out  [AW:0] FIFO occupancy, 0..DEPTH
//   Overflow   out  sticky: a sample was dropped on a full FIFO
//   Underrun   out  sticky: a transfer started on an empty FIFO
//   FsmState   out  [1:0] transfer FSM state (0 IDLE, 1 NIB0, 2 NIB1, 3 NIB2)
// -----------------------------------------------------------------------------
module tx_sample_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          ExtClk,
    input  logic          ExtResetn,
    input  logic [11:0]   AdcData,
    input  logic          AdcValid,
    input  logic          Clear,
    input  logic          Req,
    input  logic          Ack,
    output logic [11:0]   TxData,
    output logic          DataAvail,
    output logic [AW:0]   Count,
    output logic          Overflow,
    output logic          Underrun,
    output logic [1:0]    FsmState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NIB0 = 2'd1,
        NIB1 = 2'd2,
        NIB2 = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Storage is not reset: contents are only visible through the pointers.
    logic [11:0]   mem_q [DEPTH];

    state_t        state_q;
    logic [11:0]   tx_data_q;
    logic          dry_q;
    logic          ack_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underrun_q, underrun_d;
    logic          data_avail_q;

    logic          ack_fall;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          wr_en;
    logic          start_xfer;

    assign ack_fall   = ack_q & ~Ack;
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign start_xfer = (state_q == IDLE) && Req;

    // Dry is forced to 1 by Clear, so a pop can never hit an empty FIFO.
    assign pop   = (state_q == NIB2) && ack_fall && !dry_q && !Clear;
    // A pop on the same edge frees a slot, so a write on a full FIFO is
    // still accepted in that case.
    assign wr_en = AdcValid && (!fifo_full || pop) && !Clear;

    // -------------------------------------------------------------------------
    // FIFO bookkeeping (next state)
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        underrun_d = underrun_q;

        if (Clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            underrun_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            if (AdcValid && !wr_en) begin
                overflow_d = 1'b1;
            end
            if (start_xfer && fifo_empty) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ExtClk or negedge ExtResetn) begin
        if (!ExtResetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            underrun_q   <= 1'b0;
            data_avail_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            underrun_q   <= underrun_d;
            data_avail_q <= (count_d != '0);
        end
    end

    always_ff @(posedge ExtClk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= AdcData;
        end
    end

    // -------------------------------------------------------------------------
    // Transfer FSM with registered TxData
    // -------------------------------------------------------------------------
    always_ff @(posedge ExtClk or negedge ExtResetn) begin
        if (!ExtResetn) begin
            state_q   <= IDLE;
            tx_data_q <= 12'h000;
            dry_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= Ack;
            case (state_q)
                IDLE: begin
                    if (Req) begin
                        state_q <= NIB0;
                        dry_q   <= fifo_empty || Clear;
                    end else if (!Ack) begin
                        // A flush in progress empties the FIFO, so show 0
                        // rather than the head that is being discarded.
                        if (fifo_empty || Clear) begin
                            tx_data_q <= 12'h000;
                        end else begin
                            tx_data_q <= mem_q[rd_ptr_q];
                        end
                    end
                end
                NIB0: begin
                    if (ack_fall) begin
                        state_q <= NIB1;
                    end
                    if (Clear) begin
                        dry_q <= 1'b1;
                    end
                end
                NIB1: begin
                    if (ack_fall) begin
                        state_q <= NIB2;
                    end
                    if (Clear) begin
                        dry_q <= 1'b1;
                    end
                end
                NIB2: begin
                    if (ack_fall) begin
                        state_q <= IDLE;
                    end
                    if (Clear) begin
                        dry_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign TxData    = tx_data_q;
    assign DataAvail = data_avail_q;
    assign Count     = count_q;
    assign Overflow  = overflow_q;
    assign Underrun  = underrun_q;
    assign FsmState  = state_q;

endmodule

// File: tb/tb_tx_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_tx_sample_buffer
//
// Directed bench for tx_sample_buffer (DEPTH=16). Inputs change 1 ns after a
// rising edge; outputs are checked at that same point, i.e. after the edge
// has settled and well before the next one.
// -----------------------------------------------------------------------------
module tb_tx_sample_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NIB0 = 2'd1;
    localparam logic [1:0] S_NIB1 = 2'd2;
    localparam logic [1:0] S_NIB2 = 2'd3;

    logic          ExtClk;
    logic          ExtResetn;
    logic [11:0]   AdcData;
    logic          AdcValid;
    logic          Clear;
    logic          Req;
    logic          Ack;
    logic [11:0]   TxData;
    logic          DataAvail;
    logic [AW:0]   Count;
    logic          Overflow;
    logic          Underrun;
    logic [1:0]    FsmState;

    int n_cmp;
    int n_err;

    logic [11:0] exp_q[$];
    logic [11:0] exp_word;

    tx_sample_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .ExtClk    (ExtClk),
        .ExtResetn (ExtResetn),
        .AdcData   (AdcData),
        .AdcValid  (AdcValid),
        .Clear     (Clear),
        .Req       (Req),
        .Ack       (Ack),
        .TxData    (TxData),
        .DataAvail (DataAvail),
        .Count     (Count),
        .Overflow  (Overflow),
        .Underrun  (Underrun),
        .FsmState  (FsmState)
    );

    // ---------------------------------------------------------------- clock
    initial begin
        ExtClk = 1'b0;
        forever #5 ExtClk = ~ExtClk;
    end

    // --------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ExtClk);
        #1;
    endtask

    task automatic write_word(input logic [11:0] v);
        AdcValid = 1'b1;
        AdcData  = v;
        tick();
        AdcValid = 1'b0;
    endtask

    task automatic start_xfer();
        Req = 1'b1;
        tick();
        Req = 1'b0;
    endtask

    task automatic nibble();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        tick();
    endtask

    // Idle tick to load the head, then a full three-nibble transfer; the word
    // frozen in NIB0 is returned.
    task automatic read_word(output logic [11:0] w);
        tick();
        start_xfer();
        w = TxData;
        nibble();
        nibble();
        nibble();
    endtask

    // -------------------------------------------------------------- sequence
    initial begin
        n_cmp     = 0;
        n_err     = 0;
        ExtResetn = 1'b0;
        AdcData   = '0;
        AdcValid  = 1'b0;
        Clear     = 1'b0;
        Req       = 1'b0;
        Ack       = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_txdata",   TxData,    32'h000);
        check("rst_avail",    DataAvail, 32'd0);
        check("rst_count",    Count,     32'd0);
        check("rst_overflow", Overflow,  32'd0);
        check("rst_underrun", Underrun,  32'd0);
        check("rst_state",    FsmState,  S_IDLE);
        ExtResetn = 1'b1;

        // Single word through a full handshake
        write_word(12'hABC);
        check("w1_count", Count,     32'd1);
        check("w1_avail", DataAvail, 32'd1);
        tick();
        check("w1_idle_tx", TxData, 32'hABC);
        start_xfer();
        check("w1_state_nib0", FsmState, S_NIB0);
        check("w1_tx_nib0",    TxData,   32'hABC);
        nibble();
        check("w1_state_nib1", FsmState, S_NIB1);
        check("w1_tx_nib1",    TxData,   32'hABC);
        nibble();
        check("w1_state_nib2", FsmState, S_NIB2);
        check("w1_tx_nib2",    TxData,   32'hABC);
        check("w1_count_nib2", Count,    32'd1);
        nibble();
        check("w1_state_idle", FsmState, S_IDLE);
        check("w1_count_end",  Count,    32'd0);
        check("w1_avail_end",  DataAvail, 32'd0);
        check("w1_underrun",   Underrun, 32'd0);

        // Handshake on an empty FIFO
        read_word(exp_word);
        check("dry_tx",       exp_word, 32'h000);
        check("dry_underrun", Underrun, 32'd1);
        check("dry_count",    Count,    32'd0);
        check("dry_state",    FsmState, S_IDLE);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clr_underrun", Underrun, 32'd0);

        // Overfill: 17 writes, the last one is dropped
        for (int i = 1; i <= 17; i++) begin
            write_word(12'(i));
            if (i <= DEPTH) exp_q.push_back(12'(i));
        end
        check("ovf_count",    Count,    32'd16);
        check("ovf_overflow", Overflow, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            read_word(exp_word);
            check($sformatf("ovf_read%0d", i), exp_word, exp_q.pop_front());
        end
        check("ovf_count_end", Count,    32'd0);
        check("ovf_sticky",    Overflow, 32'd1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clr_overflow", Overflow, 32'd0);

        // Full FIFO: write coincides with the pop on the NIB2 Ack fall
        for (int i = 0; i < DEPTH; i++) begin
            write_word(12'h100 + 12'(i));
        end
        check("fp_count_full", Count, 32'd16);
        tick();
        start_xfer();
        check("fp_tx_head", TxData, 32'h100);
        nibble();
        nibble();
        Ack = 1'b1;
        tick();
        Ack      = 1'b0;
        AdcValid = 1'b1;
        AdcData  = 12'h3FF;
        tick();
        AdcValid = 1'b0;
        check("fp_count",    Count,    32'd16);
        check("fp_overflow", Overflow, 32'd0);
        check("fp_state",    FsmState, S_IDLE);
        for (int i = 1; i < DEPTH; i++) exp_q.push_back(12'h100 + 12'(i));
        exp_q.push_back(12'h3FF);
        for (int i = 0; i < DEPTH; i++) begin
            read_word(exp_word);
            check($sformatf("fp_read%0d", i), exp_word, exp_q.pop_front());
        end
        check("fp_count_end", Count, 32'd0);

        // Clear during NIB1 suppresses the pop
        write_word(12'hA01);
        write_word(12'hA02);
        write_word(12'hA03);
        tick();
        start_xfer();
        nibble();
        check("cl_state_nib1", FsmState, S_NIB1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("cl_count",  Count,     32'd0);
        check("cl_avail",  DataAvail, 32'd0);
        check("cl_state",  FsmState,  S_NIB1);
        check("cl_tx_hold", TxData,   32'hA01);
        nibble();
        check("cl_tx_nib2", TxData, 32'hA01);
        nibble();
        check("cl_state_end", FsmState, S_IDLE);
        check("cl_count_end", Count,    32'd0);
        tick();
        check("cl_tx_next", TxData, 32'h000);

        // Reset during NIB1 with 5 words buffered
        for (int i = 0; i < 5; i++) write_word(12'h500 + 12'(i));
        check("rr_count5", Count, 32'd5);
        tick();
        start_xfer();
        nibble();
        check("rr_state_nib1", FsmState, S_NIB1);
        ExtResetn = 1'b0;
        #1;
        check("rr_tx",    TxData,    32'h000);
        check("rr_count", Count,     32'd0);
        check("rr_avail", DataAvail, 32'd0);
        check("rr_state", FsmState,  S_IDLE);
        tick();
        ExtResetn = 1'b1;
        check("rr_count_rel", Count, 32'd0);
        write_word(12'h555);
        check("rr_first_write", Count, 32'd1);
        tick();
        check("rr_first_tx", TxData, 32'h555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tx_sample_buffer.md
TX_SAMPLE_BUFFER -- requirements
Module: tx_sample_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 12-bit words, power of two, minimum 4.
REQ-002 Parameter AW, default 4, address width, equal to log2(DEPTH).
REQ-003 ExtClk  input  1  single system clock; all logic on rising edge.
REQ-004 ExtResetn  input  1  reset, asynchronous assert, active-low.
REQ-005 AdcData  input  12  sample from the ADC capture stage.
REQ-006 AdcValid  input  1  one-cycle strobe qualifying AdcData.
REQ-007 Clear  input  1  synchronous flush of the FIFO and sticky flags.
REQ-008 Req  input  1  ESP request line, shared with the nibble transmitter.
REQ-009 Ack  input  1  acknowledge from the nibble transmitter.
REQ-010 TxData  output  12  word presented to the nibble transmitter.
REQ-011 DataAvail  output  1  FIFO holds at least one word.
REQ-012 Count  output  AW+1  FIFO occupancy, 0..DEPTH.
REQ-013 Overflow  output  1  sticky: a sample was dropped because the FIFO was full.
REQ-014 Underrun  output  1  sticky: a transfer started while the FIFO was empty.

Function
REQ-015 The FIFO SHALL be circular with wrapping write and read pointers and an explicit Count; full when Count==DEPTH, empty when Count==0.
REQ-016 On AdcValid with the FIFO not full, AdcData SHALL be written and Count incremented on the same edge.
REQ-017 On AdcValid with the FIFO full, the sample SHALL be dropped, Count SHALL be unchanged, and Overflow SHALL set.
REQ-018 The transfer FSM SHALL have states IDLE, NIB0, NIB1 and NIB2.
REQ-019 IDLE -> NIB0 on Req==1; in IDLE with Req==0 and Ack==0, TxData SHALL load the FIFO head, or 12'h000 if empty, every cycle.
REQ-020 On the IDLE->NIB0 edge, the block SHALL record whether the FIFO was empty (latched flag Dry); if empty, Underrun SHALL set.
REQ-021 NIBn -> next state on a falling edge of Ack (registered previous Ack==1, current Ack==0): NIB0->NIB1, NIB1->NIB2, NIB2->IDLE.
REQ-022 TxData SHALL be held constant in NIB0, NIB1 and NIB2.
REQ-023 On NIB2->IDLE with Dry==0, the block SHALL pop one word: advance the read pointer and decrement Count.
REQ-024 On NIB2->IDLE with Dry==1, the block SHALL NOT pop.
REQ-025 A simultaneous write and pop SHALL leave Count unchanged, with both pointers advancing.
REQ-026 A write while full coinciding with a pop SHALL be accepted, since space is freed on the same edge; Overflow SHALL NOT set.
REQ-027 Clear SHALL reset the pointers, Count, Overflow and Underrun in one cycle and SHALL have priority over a write or pop on the same edge.
REQ-028 A Clear during NIB0..NIB2 SHALL NOT change the FSM state or TxData; the pending pop SHALL be suppressed (Dry forced to 1).
REQ-029 DataAvail SHALL equal (Count!=0) as a registered output.
REQ-030 Pointer arithmetic SHALL be modulo DEPTH; Count SHALL never exceed DEPTH or fall below 0.

Reset
REQ-031 While ExtResetn==0: FSM=IDLE, pointers=0, Count=0, TxData=12'h000, DataAvail=0, Overflow=0, Underrun=0, Dry=0, registered Ack=0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer and discard all FIFO contents.
REQ-033 After release, the block SHALL accept AdcValid from the first clock edge.

Verification
REQ-034 Write 12'hABC, then run a 3-nibble handshake -> TxData==12'hABC throughout; Count goes 1->0 after the third Ack fall; DataAvail=0.
REQ-035 Write 17 samples 0x001..0x011 with DEPTH=16 -> Count==16; Overflow=1; readout order is 0x001..0x010.
REQ-036 Handshake with the FIFO empty -> TxData==12'h000; Underrun=1; Count stays 0; no pointer movement.
REQ-037 With the FIFO full, AdcValid coincides with the NIB2 Ack fall -> Count stays 16; Overflow=0; the new sample is read last.
REQ-038 Write 3 words, then Clear asserted during NIB1 -> Count=0; TxData unchanged until IDLE; no pop on completion; the next word is 12'h000.
REQ-039 ExtResetn pulsed low during NIB1 with 5 words buffered -> all outputs return to reset values immediately; Count==0 after release.
